// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus and register-file write port shared by the arbiter and its sources.
// Requester i uses bits [i*AW +: AW] of ReqAddr and [i*DW +: DW] of ReqData.
interface regfile_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 5,
   parameter int DW      = 32
);
   logic                  Hold;
   logic [NUM_REQ-1:0]    ReqValid;
   logic [NUM_REQ*AW-1:0] ReqAddr;
   logic [NUM_REQ*DW-1:0] ReqData;
   logic [NUM_REQ-1:0]    ReqReady;
   logic                  RegWrite;
   logic [AW-1:0]         WriteRegister;
   logic [DW-1:0]         WriteData;
   logic                  PendValid;
   logic [2:0]            GrantId;

   // Handshake: requester i holds ReqValid[i] with stable ReqAddr/ReqData
   // until it sees ReqValid[i] & ReqReady[i] at a rising edge; that edge is
   // the transfer. ReqReady may drop without a transfer and no state is kept
   // for a request that is withdrawn.
   modport master (
      output Hold, ReqValid, ReqAddr, ReqData,
      input  ReqReady, RegWrite, WriteRegister, WriteData, PendValid, GrantId
   );

   modport slave (
      input  Hold, ReqValid, ReqAddr, ReqData,
      output ReqReady, RegWrite, WriteRegister, WriteData, PendValid, GrantId
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// The winner is registered into a one-entry stage that drives the write port for one cycle.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 5,
   parameter int DW      = 32
) (
   input  logic                       Clk_i,
   input  logic                       Reset_i,
   regfile_write_arbiter_if.slave     bus_io,
   output logic [2:0]                 ptr_o
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0] ptr_q;
   logic          regwrite_q;
   logic [AW-1:0] waddr_q;
   logic [DW-1:0] wdata_q;
   logic [2:0]    gid_q;

   logic          hi_found, lo_found, grant_valid;
   logic [2:0]    hi_idx, lo_idx, grant_idx;
   logic [PW-1:0] ptr_d;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;
   logic [NUM_REQ-1:0] ready_c;

   // Two-pass search: first the requesters at or above the pointer, then wrap to the lowest.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_found = 1'b0;
      lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus_io.ReqValid[i]) begin
            lo_found = 1'b1;
            lo_idx   = 3'(i);
            if (i >= int'(ptr_q)) begin
               hi_found = 1'b1;
               hi_idx   = 3'(i);
            end
         end
      end
      grant_idx   = hi_found ? hi_idx : lo_idx;
      grant_valid = lo_found && !bus_io.Hold && !Reset_i;
   end

   always_comb begin
      ready_c  = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == 3'(i)) begin
            ready_c[i] = grant_valid;
            sel_addr   = bus_io.ReqAddr[i*AW +: AW];
            sel_data   = bus_io.ReqData[i*DW +: DW];
         end
      end
      if (int'(grant_idx) == NUM_REQ - 1) begin
         ptr_d = '0;
      end else begin
         ptr_d = PW'(grant_idx + 3'd1);
      end
   end

   // Writes to $zero are accepted and advance the pointer but never raise RegWrite.
   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         ptr_q      <= '0;
         regwrite_q <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         gid_q      <= '0;
      end else if (grant_valid) begin
         ptr_q      <= ptr_d;
         regwrite_q <= (sel_addr != '0);
         waddr_q    <= sel_addr;
         wdata_q    <= sel_data;
         gid_q      <= grant_idx;
      end else begin
         regwrite_q <= 1'b0;
      end
   end

   assign bus_io.ReqReady      = ready_c;
   assign bus_io.RegWrite      = regwrite_q;
   assign bus_io.PendValid     = regwrite_q;
   assign bus_io.WriteRegister = waddr_q;
   assign bus_io.WriteData     = wdata_q;
   assign bus_io.GrantId       = gid_q;
   assign ptr_o                = 3'(ptr_q);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: grants checked per cycle, writes checked by a monitor
// against an expected queue, plus a behavioural register file fed from the write port.
module tb_regfile_write_arbiter;
   localparam int NR = 4;
   localparam int AW = 5;
   localparam int DW = 32;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic [2:0] ptr_dbg;

   regfile_write_arbiter_if #(.NUM_REQ(NR), .AW(AW), .DW(DW)) bus ();

   regfile_write_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW)) dut (
      .Clk_i   (Clk),
      .Reset_i (Reset),
      .bus_io  (bus.slave),
      .ptr_o   (ptr_dbg)
   );

   // clock / reset
   always #5 Clk = ~Clk;

   logic [AW-1:0] req_addr [NR];
   logic [DW-1:0] req_data [NR];
   assign bus.ReqAddr = {req_addr[3], req_addr[2], req_addr[1], req_addr[0]};
   assign bus.ReqData = {req_data[3], req_data[2], req_data[1], req_data[0]};

   // register file driven by the arbiter output; a write in a reset cycle is lost
   logic [DW-1:0] rf [32] = '{default: '0};
   always @(posedge Clk) begin
      if (!Reset && bus.RegWrite && bus.WriteRegister != '0)
         rf[bus.WriteRegister] <= bus.WriteData;
   end

   // scoreboard
   logic [2+AW+DW:0] exp_q [$];
   int errors = 0;
   int checks = 0;
   bit done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one cycle: drive, check grant at negedge, enqueue the expected write, advance
   task automatic step(input logic rst, input logic hold, input logic [NR-1:0] valid,
                       input logic [NR-1:0] exp_ready, input string name);
      Reset        = rst;
      bus.Hold     = hold;
      bus.ReqValid = valid;
      @(negedge Clk);
      check({name, " ready"}, 64'(bus.ReqReady), 64'(exp_ready));
      for (int i = 0; i < NR; i++) begin
         if (exp_ready[i] && req_addr[i] != '0)
            exp_q.push_back({3'(i), req_addr[i], req_data[i]});
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input string name);
      step(1'b0, 1'b0, '0, '0, name);
   endtask

   // monitor: every RegWrite cycle must match the oldest expected write
   initial begin
      logic [2+AW+DW:0] e;
      while (!done) begin
         @(negedge Clk);
         if (!done) begin
            check("pendvalid", 64'(bus.PendValid), 64'(bus.RegWrite));
            if (bus.RegWrite === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected write", 64'(bus.WriteRegister), 64'hFFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("gid",   64'(bus.GrantId),       64'(e[AW+DW +: 3]));
                  check("waddr", 64'(bus.WriteRegister), 64'(e[DW +: AW]));
                  check("wdata", 64'(bus.WriteData),     64'(e[DW-1:0]));
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < NR; i++) begin
         req_addr[i] = 5'(i + 1);
         req_data[i] = 32'hA000_0000 + 32'(i);
      end
      bus.Hold     = 1'b0;
      bus.ReqValid = '0;

      // reset with all requests pending
      step(1'b1, 1'b0, 4'b1111, 4'b0000, "reset0");
      step(1'b1, 1'b0, 4'b1111, 4'b0000, "reset1");
      check("reset regwrite", 64'(bus.RegWrite), 64'd0);
      check("reset ptr", 64'(ptr_dbg), 64'd0);
      check("reset waddr", 64'(bus.WriteRegister), 64'd0);

      // all four valid: rotation 0,1,2,3,0,1,2,3
      for (int k = 0; k < 8; k++)
         step(1'b0, 1'b0, 4'b1111, 4'(1 << (k % 4)), "rr");
      idle("rr drain");
      for (int i = 0; i < NR; i++)
         check("rr regfile", 64'(rf[i + 1]), 64'(32'hA000_0000 + 32'(i)));

      // single requester 2
      req_addr[2] = 5'd5;
      req_data[2] = 32'hDEAD_BEEF;
      step(1'b0, 1'b0, 4'b0100, 4'b0100, "req2");
      check("req2 regwrite", 64'(bus.RegWrite), 64'd1);
      idle("req2 drain");
      check("req2 regfile", 64'(rf[5]), 64'hDEAD_BEEF);
      check("req2 ptr", 64'(ptr_dbg), 64'd3);

      // address 0: accepted, pointer advances, no write
      req_addr[1] = 5'd0;
      req_data[1] = 32'h1234_5678;
      step(1'b0, 1'b0, 4'b0010, 4'b0010, "zero");
      check("zero regwrite", 64'(bus.RegWrite), 64'd0);
      check("zero ptr", 64'(ptr_dbg), 64'd2);
      check("zero gid", 64'(bus.GrantId), 64'd1);
      idle("zero drain");
      check("zero regfile", 64'(rf[0]), 64'd0);

      // stage a write from req3 then hold: staged write commits, no new grants
      req_addr[3] = 5'd6;
      req_data[3] = 32'h5A5A_5A5A;
      step(1'b0, 1'b0, 4'b1000, 4'b1000, "pre-hold");
      for (int k = 0; k < 3; k++)
         step(1'b0, 1'b1, 4'b1001, 4'b0000, "hold");
      check("hold regwrite", 64'(bus.RegWrite), 64'd0);
      check("hold regfile", 64'(rf[6]), 64'h5A5A_5A5A);
      req_data[0] = 32'hB0B0_0001;
      step(1'b0, 1'b0, 4'b1001, 4'b0001, "release0");
      step(1'b0, 1'b0, 4'b1000, 4'b1000, "release3");
      idle("release drain");
      check("release regfile", 64'(rf[1]), 64'hB0B0_0001);
      check("release ptr", 64'(ptr_dbg), 64'd0);

      // reset right after acceptance discards the staged write
      req_addr[1] = 5'd7;
      req_data[1] = 32'h7777_7777;
      step(1'b0, 1'b0, 4'b0010, 4'b0010, "pre-reset");
      step(1'b1, 1'b0, 4'b0010, 4'b0000, "mid-reset");
      check("mid-reset regwrite", 64'(bus.RegWrite), 64'd0);
      check("mid-reset ptr", 64'(ptr_dbg), 64'd0);
      check("mid-reset gid", 64'(bus.GrantId), 64'd0);
      check("mid-reset wdata", 64'(bus.WriteData), 64'd0);
      idle("post-reset");
      check("post-reset regfile", 64'(rf[7]), 64'd0);
      step(1'b0, 1'b0, 4'b1111, 4'b0001, "post-reset grant");
      idle("final drain");

      check("queue empty", 64'(exp_q.size()), 64'd0);
      done = 1'b1;
      @(negedge Clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
